// File: rtl/control_bus_seq.sv
// Command-word write sequencer: synchronizes the bus strobes, latches write data
// and steps through ICW1..ICW4 initialization into READY. CTRL_BUS_SEQ_ERR_EN adds seq_err.
module control_bus_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic                  a0,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] internal_bus,
  output logic                  icw1_wr,
  output logic                  icw2_wr,
  output logic                  icw3_wr,
  output logic                  icw4_wr,
  output logic                  ocw1_wr,
  output logic                  ocw2_wr,
  output logic                  ocw3_wr,
`ifdef CTRL_BUS_SEQ_ERR_EN
  output logic                  seq_err,
`endif
  output logic                  read,
  output logic                  init_done,
  output logic                  sngl,
  output logic                  ic4
);

  // SYNC_STAGES == 0 still registers the strobes once.
  localparam int NSTG = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
  localparam logic [3:0] SYNC_IDLE = 4'b1110;  // {cs_n, rd_n, wr_n, a0}

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  // Pulse vector bit positions: {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3}
  localparam logic [6:0] P_ICW1 = 7'b1000000;
  localparam logic [6:0] P_ICW2 = 7'b0100000;
  localparam logic [6:0] P_ICW3 = 7'b0010000;
  localparam logic [6:0] P_ICW4 = 7'b0001000;
  localparam logic [6:0] P_OCW1 = 7'b0000100;
  localparam logic [6:0] P_OCW2 = 7'b0000010;
  localparam logic [6:0] P_OCW3 = 7'b0000001;

  logic [3:0]            sync_q [NSTG];
  logic [3:0]            sync_d [NSTG];
  logic                  cs_n_sync, rd_n_sync, wr_n_sync, a0_sync;
  logic                  wa, commit, is_icw1;
  logic                  wa_q, wa_d;
  logic                  a0_lat_q, a0_lat_d;
  logic                  read_q, read_d;
  logic [DATA_WIDTH-1:0] internal_bus_q, internal_bus_d;
  state_t                state_q, state_d;
  logic [6:0]            pulse_q, pulse_d;
  logic                  sngl_q, sngl_d, ic4_q, ic4_d;
  logic                  init_done_q, init_done_d;

  // Synchronizer shift chain.
  always_comb begin
    sync_d[0] = {cs_n, rd_n, wr_n, a0};
    for (int i = 1; i < NSTG; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer registers, reset to the inactive strobe levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSTG; i++) begin
        sync_q[i] <= SYNC_IDLE;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign {cs_n_sync, rd_n_sync, wr_n_sync, a0_sync} = sync_q[NSTG-1];
  assign wa      = ~wr_n_sync & ~cs_n_sync;
  assign commit  = wa_q & ~wa;
  assign is_icw1 = ~a0_lat_q & internal_bus_q[4];

  // Write capture and read level; a concurrent write masks the read.
  always_comb begin
    wa_d   = wa;
    read_d = ~rd_n_sync & ~cs_n_sync & ~wa;
    if (wa) begin
      internal_bus_d = data_in;
      a0_lat_d       = a0_sync;
    end else begin
      internal_bus_d = internal_bus_q;
      a0_lat_d       = a0_lat_q;
    end
  end

  // Write capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wa_q           <= 1'b0;
      a0_lat_q       <= 1'b0;
      read_q         <= 1'b0;
      internal_bus_q <= '0;
    end else begin
      wa_q           <= wa_d;
      a0_lat_q       <= a0_lat_d;
      read_q         <= read_d;
      internal_bus_q <= internal_bus_d;
    end
  end

  // Command decode on the trailing edge of a write; only bits [4:0] are looked at.
  always_comb begin
    state_d = state_q;
    pulse_d = 7'd0;
    sngl_d  = sngl_q;
    ic4_d   = ic4_q;
    if (commit) begin
      if (is_icw1) begin
        pulse_d = P_ICW1;
        sngl_d  = internal_bus_q[1];
        ic4_d   = internal_bus_q[0];
        state_d = WAIT_ICW2;
      end else begin
        case (state_q)
          UNINIT: begin
            state_d = UNINIT;
          end
          WAIT_ICW2: begin
            if (a0_lat_q) begin
              pulse_d = P_ICW2;
              if (!sngl_q) begin
                state_d = WAIT_ICW3;
              end else if (ic4_q) begin
                state_d = WAIT_ICW4;
              end else begin
                state_d = READY;
              end
            end else begin
              state_d = WAIT_ICW2;
            end
          end
          WAIT_ICW3: begin
            if (a0_lat_q) begin
              pulse_d = P_ICW3;
              state_d = ic4_q ? WAIT_ICW4 : READY;
            end else begin
              state_d = WAIT_ICW3;
            end
          end
          WAIT_ICW4: begin
            if (a0_lat_q) begin
              pulse_d = P_ICW4;
              state_d = READY;
            end else begin
              state_d = WAIT_ICW4;
            end
          end
          READY: begin
            if (a0_lat_q) begin
              pulse_d = P_OCW1;
            end else if (internal_bus_q[3]) begin
              pulse_d = P_OCW3;
            end else begin
              pulse_d = P_OCW2;
            end
          end
          default: begin
            state_d = UNINIT;
          end
        endcase
      end
    end else begin
      pulse_d = 7'd0;
    end
    init_done_d = (state_d == READY);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UNINIT;
      pulse_q     <= 7'd0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef CTRL_BUS_SEQ_ERR_EN
  logic seq_err_q, seq_err_d, ignored;

  // Sticky flag for commits dropped before READY; the next ICW1 clears it.
  always_comb begin
    ignored = commit & ~is_icw1 &
              ((state_q == UNINIT) | ((state_q != READY) & ~a0_lat_q));
    if (commit & is_icw1) begin
      seq_err_d = 1'b0;
    end else if (ignored) begin
      seq_err_d = 1'b1;
    end else begin
      seq_err_d = seq_err_q;
    end
  end

  // Sequence error register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`endif

  assign internal_bus = internal_bus_q;
  assign {icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr} = pulse_q;
  assign read      = read_q;
  assign init_done = init_done_q;
  assign sngl      = sngl_q;
  assign ic4       = ic4_q;

endmodule

// File: tb/tb_control_bus_seq.sv
// Directed self-checking bench for control_bus_seq (DATA_WIDTH=16, SYNC_STAGES=2).
module tb_control_bus_seq;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs_n, rd_n, wr_n, a0;
  logic [DW-1:0] data_in;
  logic [DW-1:0] internal_bus;
  logic          icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr;
  logic          read, init_done, sngl, ic4;
`ifdef CTRL_BUS_SEQ_ERR_EN
  logic          seq_err;
`endif

  int         n_pass = 0;
  int         n_total = 0;
  logic [6:0] hit_vec;
  int         hit_cnt;
  int         hit_idx;
  logic       multi;
  logic [6:0] read_hist;
  logic [6:0] pulses;

  control_bus_seq #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
    .data_in(data_in), .internal_bus(internal_bus),
    .icw1_wr(icw1_wr), .icw2_wr(icw2_wr), .icw3_wr(icw3_wr), .icw4_wr(icw4_wr),
    .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr),
`ifdef CTRL_BUS_SEQ_ERR_EN
    .seq_err(seq_err),
`endif
    .read(read), .init_done(init_done), .sngl(sngl), .ic4(ic4)
  );

  always #5 clk = ~clk;

  assign pulses = {icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // Drive strobes low and hold long enough to pass the synchronizer and load data.
  task automatic start_write(input logic a, input logic [DW-1:0] d);
    cs_n    = 1'b0;
    wr_n    = 1'b0;
    a0      = a;
    data_in = d;
    tick();
    tick();
    tick();
  endtask

  // Record pulses and read over six cycles following the release.
  task automatic watch();
    hit_vec   = 7'd0;
    hit_cnt   = 0;
    hit_idx   = -1;
    multi     = 1'b0;
    read_hist = 7'd0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      read_hist[i] = read;
      if (pulses != 7'd0) begin
        hit_cnt++;
        hit_vec = hit_vec | pulses;
        if (hit_idx < 0) hit_idx = i;
        if ($countones(pulses) > 1) multi = 1'b1;
      end
    end
  endtask

  task automatic do_write(input logic a, input logic [DW-1:0] d);
    start_write(a, d);
    cs_n = 1'b1;
    wr_n = 1'b1;
    watch();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; data_in = 16'h0000;
    tick();
    tick();
    n_total++;
    if (pulses !== 7'd0) $display("FAIL reset_pulses: got %b want 0000000", pulses); else n_pass++;
    n_total++;
    if ({internal_bus, read, init_done, sngl, ic4} !== 20'd0)
      $display("FAIL reset_outputs: got bus=%h rd=%b done=%b sngl=%b ic4=%b want all 0",
               internal_bus, read, init_done, sngl, ic4);
    else n_pass++;
`ifdef CTRL_BUS_SEQ_ERR_EN
    n_total++;
    if (seq_err !== 1'b0) $display("FAIL reset_seq_err: got %b want 0", seq_err); else n_pass++;
`endif
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_full_init();
    do_write(1'b0, 16'h0010);
    n_total++;
    if (hit_vec !== 7'b1000000) $display("FAIL init_icw1: got %b want 1000000", hit_vec); else n_pass++;
    n_total++;
    if (hit_cnt != 1 || hit_idx != 3 || multi)
      $display("FAIL init_icw1_timing: got cnt=%0d idx=%0d multi=%b want cnt=1 idx=3 multi=0", hit_cnt, hit_idx, multi);
    else n_pass++;
    n_total++;
    if ({sngl, ic4, init_done} !== 3'b000)
      $display("FAIL init_icw1_bits: got sngl/ic4/done=%b want 000", {sngl, ic4, init_done});
    else n_pass++;
    do_write(1'b1, 16'h0020);
    n_total++;
    if (hit_vec !== 7'b0100000 || hit_cnt != 1 || hit_idx != 3)
      $display("FAIL init_icw2: got %b cnt=%0d idx=%0d want 0100000 cnt=1 idx=3", hit_vec, hit_cnt, hit_idx);
    else n_pass++;
    n_total++;
    if (init_done !== 1'b0) $display("FAIL init_done_early: got %b want 0", init_done); else n_pass++;
    do_write(1'b1, 16'h0004);
    n_total++;
    if (hit_vec !== 7'b0010000 || hit_cnt != 1 || hit_idx != 3)
      $display("FAIL init_icw3: got %b cnt=%0d idx=%0d want 0010000 cnt=1 idx=3", hit_vec, hit_cnt, hit_idx);
    else n_pass++;
    n_total++;
    if (init_done !== 1'b1) $display("FAIL init_done_ready: got %b want 1", init_done); else n_pass++;
    n_total++;
    if (internal_bus !== 16'h0004) $display("FAIL init_bus: got %h want 0004", internal_bus); else n_pass++;
  endtask

  task automatic test_ocw();
    do_write(1'b1, 16'h00FF);
    n_total++;
    if (hit_vec !== 7'b0000100 || hit_cnt != 1 || hit_idx != 3 || multi)
      $display("FAIL ocw1: got %b cnt=%0d idx=%0d want 0000100 cnt=1 idx=3", hit_vec, hit_cnt, hit_idx);
    else n_pass++;
    do_write(1'b0, 16'h0020);
    n_total++;
    if (hit_vec !== 7'b0000010 || hit_cnt != 1 || hit_idx != 3 || multi)
      $display("FAIL ocw2: got %b cnt=%0d idx=%0d want 0000010 cnt=1 idx=3", hit_vec, hit_cnt, hit_idx);
    else n_pass++;
    do_write(1'b0, 16'h000B);
    n_total++;
    if (hit_vec !== 7'b0000001 || hit_cnt != 1 || hit_idx != 3 || multi)
      $display("FAIL ocw3: got %b cnt=%0d idx=%0d want 0000001 cnt=1 idx=3", hit_vec, hit_cnt, hit_idx);
    else n_pass++;
    // Upper byte has bits 4 and 3 set but must not affect decode.
    do_write(1'b0, 16'hFF00);
    n_total++;
    if (hit_vec !== 7'b0000010 || hit_cnt != 1)
      $display("FAIL ocw2_high_bits: got %b cnt=%0d want 0000010 cnt=1", hit_vec, hit_cnt);
    else n_pass++;
    n_total++;
    if (internal_bus !== 16'hFF00) $display("FAIL ocw_bus_wide: got %h want ff00", internal_bus); else n_pass++;
  endtask

  task automatic test_single_icw4();
    do_write(1'b0, 16'h0013);
    n_total++;
    if (hit_vec !== 7'b1000000 || {sngl, ic4, init_done} !== 3'b110)
      $display("FAIL single_icw1: got %b sngl/ic4/done=%b want 1000000 110", hit_vec, {sngl, ic4, init_done});
    else n_pass++;
    do_write(1'b1, 16'h0008);
    n_total++;
    if (hit_vec !== 7'b0100000 || hit_cnt != 1)
      $display("FAIL single_icw2: got %b cnt=%0d want 0100000 cnt=1", hit_vec, hit_cnt);
    else n_pass++;
    do_write(1'b1, 16'h0001);
    n_total++;
    if (hit_vec !== 7'b0001000 || hit_cnt != 1 || hit_idx != 3)
      $display("FAIL single_icw4: got %b cnt=%0d idx=%0d want 0001000 cnt=1 idx=3", hit_vec, hit_cnt, hit_idx);
    else n_pass++;
    n_total++;
    if (init_done !== 1'b1) $display("FAIL single_ready: got %b want 1", init_done); else n_pass++;
  endtask

  task automatic test_ignored();
    apply_reset();
    do_write(1'b1, 16'h0020);
    n_total++;
    if (hit_vec !== 7'd0 || init_done !== 1'b0)
      $display("FAIL uninit_a0_ignored: got %b done=%b want 0000000 done=0", hit_vec, init_done);
    else n_pass++;
    do_write(1'b0, 16'h0010);
    n_total++;
    if (hit_vec !== 7'b1000000) $display("FAIL ign_icw1: got %b want 1000000", hit_vec); else n_pass++;
    do_write(1'b0, 16'h0000);
    n_total++;
    if (hit_vec !== 7'd0) $display("FAIL wait_a0_0_ignored: got %b want 0000000", hit_vec); else n_pass++;
    do_write(1'b1, 16'h0020);
    n_total++;
    if (hit_vec !== 7'b0100000) $display("FAIL ign_still_icw2: got %b want 0100000", hit_vec); else n_pass++;
  endtask

  task automatic test_restart();
    do_write(1'b0, 16'h0011);
    n_total++;
    if (hit_vec !== 7'b1000000 || hit_cnt != 1 || {sngl, ic4} !== 2'b01)
      $display("FAIL restart_icw1: got %b cnt=%0d sngl/ic4=%b want 1000000 cnt=1 01", hit_vec, hit_cnt, {sngl, ic4});
    else n_pass++;
    do_write(1'b1, 16'h0020);
    n_total++;
    if (hit_vec !== 7'b0100000) $display("FAIL restart_icw2: got %b want 0100000", hit_vec); else n_pass++;
  endtask

  task automatic test_rd_wr();
    rd_n = 1'b0;
    start_write(1'b1, 16'h0004);
    n_total++;
    if (read !== 1'b0) $display("FAIL rdwr_read_masked: got %b want 0", read); else n_pass++;
    wr_n = 1'b1;
    watch();
    n_total++;
    if (hit_vec !== 7'b0010000 || hit_idx != 3)
      $display("FAIL rdwr_commit: got %b idx=%0d want 0010000 idx=3", hit_vec, hit_idx);
    else n_pass++;
    n_total++;
    if (read_hist[3:1] !== 3'b100) $display("FAIL rdwr_read_rise: got %b want 100", read_hist[3:1]); else n_pass++;
    cs_n = 1'b1;
    rd_n = 1'b1;
    tick(); tick(); tick(); tick();
    n_total++;
    if (read !== 1'b0) $display("FAIL rdwr_read_fall: got %b want 0", read); else n_pass++;
  endtask

  task automatic test_cs_release();
    start_write(1'b1, 16'h0002);
    cs_n = 1'b1;
    watch();
    wr_n = 1'b1;
    n_total++;
    if (hit_vec !== 7'b0001000 || hit_cnt != 1 || hit_idx != 3)
      $display("FAIL cs_release_commit: got %b cnt=%0d idx=%0d want 0001000 cnt=1 idx=3", hit_vec, hit_cnt, hit_idx);
    else n_pass++;
    n_total++;
    if (init_done !== 1'b1) $display("FAIL cs_release_ready: got %b want 1", init_done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_write(1'b0, 16'h0013);
    start_write(1'b1, 16'h0055);
    tick();
    reset = 1'b1;
    #1;
    n_total++;
    if ({pulses, internal_bus, read, init_done, sngl, ic4} !== 27'd0)
      $display("FAIL midreset_outputs: got p=%b bus=%h rd=%b done=%b sngl=%b ic4=%b want all 0",
               pulses, internal_bus, read, init_done, sngl, ic4);
    else n_pass++;
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();
    reset = 1'b0;
    watch();
    n_total++;
    if (hit_vec !== 7'd0 || internal_bus !== 16'h0000)
      $display("FAIL midreset_no_pulse: got %b bus=%h want 0000000 bus=0000", hit_vec, internal_bus);
    else n_pass++;
    // A WAIT_ICW2 state would answer this with icw2_wr.
    do_write(1'b1, 16'h0020);
    n_total++;
    if (hit_vec !== 7'd0 || init_done !== 1'b0)
      $display("FAIL midreset_uninit: got %b done=%b want 0000000 done=0", hit_vec, init_done);
    else n_pass++;
`ifdef CTRL_BUS_SEQ_ERR_EN
    do_write(1'b0, 16'h0000);
    n_total++;
    if (seq_err !== 1'b1) $display("FAIL seq_err_set: got %b want 1", seq_err); else n_pass++;
    do_write(1'b0, 16'h0010);
    n_total++;
    if (seq_err !== 1'b0) $display("FAIL seq_err_clear: got %b want 0", seq_err); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_full_init();
    test_ocw();
    test_single_icw4();
    test_ignored();
    test_restart();
    test_rd_wr();
    test_cs_release();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
